// File: rtl/fire2_pkg.sv
// Shared definitions for the weight ROM sequencer: FSM state encoding and
// default geometry of the weight store.
package fire2_pkg;

  localparam int DEF_ADDR   = 10;
  localparam int DEF_DEPTH  = 576;
  localparam int DEF_PASSES = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } seq_state_e;

endpackage

// File: rtl/weight_rom_sequencer_if.sv
// Control/streaming bundle between a job controller (master) and the
// weight ROM sequencer (slave).
interface weight_rom_sequencer_if
  import fire2_pkg::*;
#(
  parameter int ADDR = DEF_ADDR
);
  logic            start;
  logic            abort;
  logic            stall;
  logic [ADDR-1:0] rom_address;
  logic            rom_valid;
  logic            rom_last;
  logic [7:0]      pass_idx;
  logic            busy;
  logic            done;

  modport master (
    output start, abort, stall,
    input  rom_address, rom_valid, rom_last, pass_idx, busy, done
  );

  modport slave (
    input  start, abort, stall,
    output rom_address, rom_valid, rom_last, pass_idx, busy, done
  );
endinterface

// File: rtl/weight_rom_sequencer_wrap_counter.sv
// Enabled up-counter that wraps to zero after MAX and flags the terminal
// count; clear has priority over enable.
module wrap_counter #(
  parameter int          WIDTH = 8,
  parameter int unsigned MAX   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  assign tc = (count == WIDTH'(MAX));

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/weight_rom_sequencer.sv
// Replays DEPTH weight addresses PASSES times into an external registered
// ROM, with stall back-pressure, abort, and a one-cycle done pulse.
module weight_rom_sequencer
  import fire2_pkg::*;
#(
  parameter int ADDR   = DEF_ADDR,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int PASSES = DEF_PASSES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  weight_rom_sequencer_if.slave  bus
);

  seq_state_e      state;
  logic            rom_valid_q;
  logic            rom_last_q;
  logic            busy_q;
  logic            done_q;

  logic [ADDR-1:0] addr_q;
  logic [7:0]      pass_q;
  logic            addr_tc;
  logic            pass_tc;
  logic            issue;
  logic            final_word;
  logic            ctr_clear;

  // abort outside IDLE wins over stall, wrap and terminal transitions.
  assign issue      = (state == ST_RUN) && !bus.stall && !bus.abort;
  assign final_word = addr_tc && pass_tc;
  assign ctr_clear  = (state == ST_IDLE) || (state == ST_DONE) || bus.abort;

  wrap_counter #(
    .WIDTH (ADDR),
    .MAX   (DEPTH - 1)
  ) u_addr_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (ctr_clear),
    .en    (issue && !final_word),
    .count (addr_q),
    .tc    (addr_tc)
  );

  wrap_counter #(
    .WIDTH (8),
    .MAX   (PASSES - 1)
  ) u_pass_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (ctr_clear),
    .en    (issue && addr_tc && !pass_tc),
    .count (pass_q),
    .tc    (pass_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rom_valid_q <= 1'b0;
      rom_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (bus.abort && state != ST_IDLE) begin
      state       <= ST_IDLE;
      rom_valid_q <= 1'b0;
      rom_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start && !bus.abort) begin
            state  <= ST_RUN;
            busy_q <= 1'b1;
          end
        end
        ST_RUN: begin
          // Valid trails issue by one cycle to line up with the ROM read.
          rom_valid_q <= issue;
          if (issue && final_word) begin
            state      <= ST_DRAIN;
            rom_last_q <= 1'b1;
          end
        end
        ST_DRAIN: begin
          state       <= ST_DONE;
          rom_valid_q <= 1'b0;
          rom_last_q  <= 1'b0;
          done_q      <= 1'b1;
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.rom_address = addr_q;
  assign bus.pass_idx    = pass_q;
  assign bus.rom_valid   = rom_valid_q;
  assign bus.rom_last    = rom_last_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule
